sync_fifo_param: RTL
====================

Name: sync_fifo_param

Overview:
- Parametrised single-clock synchronous FIFO; next generation of the team's fixed 16-bit FIFO.
- Adds configurable width and depth, a fill-level count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags.
- Adds a selectable read mode: standard registered read or first-word-fall-through (FWFT).
- Sits between producer and consumer datapaths in the same clock domain.

Parameters:
- WIDTH, 16: data word width in bits.
- DEPTH, 4: number of entries; power of two, >= 2.
- AF_THRESH, DEPTH-1: almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 1: almost_empty asserts when count <= AE_THRESH.
- FWFT, 0: 0 = registered read, 1 = first-word-fall-through.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- data_in  in  WIDTH  write data.
- data_out  out  WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  $clog2(DEPTH)+1  current number of stored entries.
- overflow  out  1  sticky; a write was rejected.
- underflow  out  1  sticky; a read was rejected.

Behaviour:
- Reset (rst_n==0 at a rising edge):
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - data_out = 0, overflow = 0, underflow = 0.
  - Resulting outputs: empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - Memory contents need not be cleared.
  - Reset mid-operation discards all stored data on that edge; the wr_en/rd_en sampled on that edge are ignored.
- Pointers:
  - $clog2(DEPTH) bits each; wrap from DEPTH-1 to 0 naturally.
  - count is kept as a separate register.
- Accept rules (evaluated on the pre-edge state):
  - do_rd = rd_en & !empty.
  - do_wr = wr_en & (!full | rd_en). A write into a full FIFO is accepted when a read happens on the same edge.
  - If empty, rd_en and wr_en are all high: the write is accepted, the read is rejected and underflow sets. There is no bypass.
- Updates on each rising edge:
  - do_wr: mem[wr_ptr] <= data_in; wr_ptr increments.
  - do_rd: rd_ptr increments.
  - count: +1 on do_wr only; -1 on do_rd only; unchanged when both or neither occur.
- Errors:
  - wr_en & !do_wr sets overflow.
  - rd_en & !do_rd sets underflow.
  - Both stay set until reset. A rejected access changes no other state.
- FWFT=0 (registered read):
  - On do_rd, data_out <= mem[rd_ptr]; read latency is 1 cycle.
  - Otherwise data_out holds its last value.
  - The value after the first read following reset is the oldest word.
- FWFT=1:
  - data_out = mem[rd_ptr] combinationally. It is valid whenever empty == 0 and shows the head word with zero latency.
  - rd_en acts as a pop/acknowledge.
  - data_out while empty is don't-care, but must equal 0 out of reset.
- Status flags:
  - full, empty, almost_full and almost_empty are combinational decodes of the registered count, so they reflect state after the edge.
  - No flag glitches on wr_en/rd_en.
- Widths: count never exceeds DEPTH and never goes below 0. Thresholds outside 0..DEPTH make the corresponding flag constant.
- Ordering: strict FIFO order across any number of pointer wraps.

Test Plan (WIDTH=16, DEPTH=4, AF_THRESH=3, AE_THRESH=1 unless noted):
1. Reset, then write ABCD and 1234 in back-to-back cycles -> count=2, empty=0, full=0, almost_empty=0, almost_full=0. Read two cycles with FWFT=0 -> data_out = ABCD then 1234 one cycle after each rd_en; then empty=1, count=0.
2. Write 1111, 2222, 3333, 4444 -> almost_full=1 at count=3, full=1 at count=4. A fifth write of 5555 while full -> rejected, overflow=1, count stays 4. Draining returns 1111..4444 in order.
3. Full FIFO, simultaneous rd_en+wr_en with 6666 -> data_out=1111, count stays 4, full stays 1, overflow unchanged. After the drain the last word read is 6666.
4. Empty FIFO, rd_en alone -> underflow=1, count=0, data_out unchanged. Empty FIFO, rd_en+wr_en with 7777 -> count=1 and underflow remains set.
5. Ten write/read pairs of 0x0000..0x0009, interleaved to wrap the pointers twice -> outputs appear in the same order, and count never exceeds 4.
6. FWFT=1: write 9ABC -> data_out=9ABC in the cycle after the write, before any rd_en. Pop -> empty=1. Assert rst_n=0 with 3 entries stored -> on the next edge count=0, empty=1, flags cleared, data_out=0.

Source files
------------

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with configurable width/depth, fill-level
// count, almost-full/almost-empty thresholds, sticky overflow/underflow
// flags, and either a registered read port or first-word-fall-through.
module sync_fifo_param #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [CW-1:0] DEPTH_V = CW'(DEPTH);

  // Thresholds are clamped into the representable count range; a threshold
  // beyond the reachable range pins the flag to a constant instead.
  localparam int AF_CL = (AF_THRESH < 0) ? 0 : ((AF_THRESH > DEPTH) ? DEPTH : AF_THRESH);
  localparam int AE_CL = (AE_THRESH < 0) ? 0 : ((AE_THRESH > DEPTH) ? DEPTH : AE_THRESH);
  localparam logic [CW-1:0] AF_V = CW'(AF_CL);
  localparam logic [CW-1:0] AE_V = CW'(AE_CL);
  localparam bit AF_NEVER = (AF_THRESH > DEPTH);
  localparam bit AE_NEVER = (AE_THRESH < 0);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             overflow_r;
  logic             underflow_r;

  logic             empty_s;
  logic             full_s;
  logic             do_wr_s;
  logic             do_rd_s;
  logic [CW-1:0]    count_nxt_s;
  logic             almost_full_s;
  logic             almost_empty_s;

  // Accept decisions from the pre-edge occupancy; a full FIFO still takes a
  // write when a read frees a slot on the same edge.
  always_comb begin
    empty_s = (count_r == '0);
    full_s  = (count_r == DEPTH_V);
    do_rd_s = rd_en & ~empty_s;
    do_wr_s = wr_en & (~full_s | rd_en);
  end

  // Next occupancy: simultaneous read and write cancel out.
  always_comb begin
    count_nxt_s = count_r;
    case ({do_wr_s, do_rd_s})
      2'b10:   count_nxt_s = count_r + CW'(1'b1);
      2'b01:   count_nxt_s = count_r - CW'(1'b1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, occupancy and sticky error state with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      count_r     <= count_nxt_s;
      overflow_r  <= overflow_r | (wr_en & ~do_wr_s);
      underflow_r <= underflow_r | (rd_en & ~do_rd_s);
    end
  end

  // Storage array; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (rst_n && do_wr_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word shown with zero latency; forced to zero while empty so the
      // uninitialised array never leaks out after reset.
      always_comb begin
        if (empty_s) begin
          data_out = '0;
        end else begin
          data_out = mem_r[rd_ptr_r];
        end
      end
    end else begin : g_reg
      logic [WIDTH-1:0] dout_r;

      // Registered read port: captures the head word on each accepted read.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          dout_r <= '0;
        end else if (do_rd_s) begin
          dout_r <= mem_r[rd_ptr_r];
        end
      end

      assign data_out = dout_r;
    end
  endgenerate

  // Threshold flags decoded from the registered count only.
  always_comb begin
    if (AF_NEVER) begin
      almost_full_s = 1'b0;
    end else begin
      almost_full_s = (count_r >= AF_V);
    end
    if (AE_NEVER) begin
      almost_empty_s = 1'b0;
    end else begin
      almost_empty_s = (count_r <= AE_V);
    end
  end

  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = almost_full_s;
  assign almost_empty = almost_empty_s;
  assign count        = count_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule
